// File: rtl/single_sum_v.sv
// single_sum_v: serial single-precision vector reduction.
// Sums the WIDTH elements of vector_a left to right through one shared
// single_add_1clk adder: ((v0 + v1) + v2) + ...
// Optional feature macro: SINGLE_SUM_NAN_FLAG_EN adds the nan_inf output,
// flagging any accepted operand with an all-ones exponent.

// Single-cycle-latency IEEE-754 binary32 adder, round-to-nearest-even.
// Subnormal inputs are treated as zero and underflowing results flush to
// a signed zero; any NaN input or inf + (-inf) yields the quiet NaN 7FC00000.
module single_add_1clk (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic [31:0] c
);

  // Leading-zero count of a 27-bit mantissa; the highest set bit wins.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) begin
        n = 5'(26 - i);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  logic               sa_s, sb_s;
  logic [7:0]         ea_s, eb_s;
  logic [22:0]        fa_s, fb_s;
  logic [23:0]        ma_s, mb_s;
  logic               a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_ge_s;
  logic               s_big_s, s_small_s;
  logic [7:0]         e_big_s, e_small_s, shift_s;
  logic [23:0]        m_big_s, m_small_s;
  logic [49:0]        wide_s;
  logic [26:0]        big_ext_s, small_ext_s, norm_s;
  logic [27:0]        sum_raw_s;
  logic [4:0]         lz_s;
  logic signed [9:0]  exp_n_s, exp_r_s;
  logic               round_up_s;
  logic [24:0]        mant_r_s;
  logic [22:0]        frac_r_s;
  logic [31:0]        c_s;
  logic               out_valid_q;
  logic [31:0]        c_q;

  assign sa_s    = a[31];
  assign sb_s    = b[31];
  assign ea_s    = a[30:23];
  assign eb_s    = b[30:23];
  assign fa_s    = a[22:0];
  assign fb_s    = b[22:0];
  assign ma_s    = (ea_s == 8'h00) ? 24'd0 : {1'b1, fa_s};
  assign mb_s    = (eb_s == 8'h00) ? 24'd0 : {1'b1, fb_s};
  assign a_nan_s = (ea_s == 8'hFF) && (fa_s != 23'd0);
  assign b_nan_s = (eb_s == 8'hFF) && (fb_s != 23'd0);
  assign a_inf_s = (ea_s == 8'hFF) && (fa_s == 23'd0);
  assign b_inf_s = (eb_s == 8'hFF) && (fb_s == 23'd0);
  assign a_ge_s  = ({ea_s, fa_s} >= {eb_s, fb_s});

  // Order operands so the larger magnitude is always the minuend.
  always_comb begin
    if (a_ge_s) begin
      s_big_s   = sa_s;  e_big_s   = ea_s;  m_big_s   = ma_s;
      s_small_s = sb_s;  e_small_s = eb_s;  m_small_s = mb_s;
    end else begin
      s_big_s   = sb_s;  e_big_s   = eb_s;  m_big_s   = mb_s;
      s_small_s = sa_s;  e_small_s = ea_s;  m_small_s = ma_s;
    end
  end

  // Align the smaller mantissa, keeping guard, round and sticky bits.
  always_comb begin
    shift_s   = e_big_s - e_small_s;
    wide_s    = {m_small_s, 26'd0} >> shift_s;
    big_ext_s = {m_big_s, 3'b000};
    if (shift_s > 8'd49) begin
      small_ext_s = {26'd0, |m_small_s};
    end else begin
      small_ext_s = {wide_s[49:24], |wide_s[23:0]};
    end
  end

  // Add or subtract magnitudes and normalise to a leading one at bit 26.
  always_comb begin
    sum_raw_s = 28'd0;
    lz_s      = 5'd0;
    norm_s    = 27'd0;
    exp_n_s   = $signed({2'b00, e_big_s});
    if (s_big_s == s_small_s) begin
      sum_raw_s = {1'b0, big_ext_s} + {1'b0, small_ext_s};
      if (sum_raw_s[27]) begin
        norm_s  = {sum_raw_s[27:2], sum_raw_s[1] | sum_raw_s[0]};
        exp_n_s = exp_n_s + 10'sd1;
      end else begin
        norm_s  = sum_raw_s[26:0];
      end
    end else begin
      sum_raw_s = {1'b0, big_ext_s - small_ext_s};
      lz_s      = lzc27(sum_raw_s[26:0]);
      norm_s    = sum_raw_s[26:0] << lz_s;
      exp_n_s   = exp_n_s - $signed({5'd0, lz_s});
    end
  end

  // Round to nearest, ties to even; a mantissa carry bumps the exponent.
  always_comb begin
    round_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
    mant_r_s   = {1'b0, norm_s[26:3]} + {24'd0, round_up_s};
    if (mant_r_s[24]) begin
      exp_r_s  = exp_n_s + 10'sd1;
      frac_r_s = mant_r_s[23:1];
    end else begin
      exp_r_s  = exp_n_s;
      frac_r_s = mant_r_s[22:0];
    end
  end

  // Special-value selection, overflow to infinity, underflow to zero.
  always_comb begin
    if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (sa_s != sb_s))) begin
      c_s = 32'h7FC0_0000;
    end else if (a_inf_s) begin
      c_s = a;
    end else if (b_inf_s) begin
      c_s = b;
    end else if (!norm_s[26]) begin
      c_s = {s_big_s & s_small_s, 31'd0};
    end else if (exp_r_s >= 10'sd255) begin
      c_s = {s_big_s, 8'hFF, 23'd0};
    end else if (exp_r_s <= 10'sd0) begin
      c_s = {s_big_s, 31'd0};
    end else begin
      c_s = {s_big_s, exp_r_s[7:0], frac_r_s};
    end
  end

  // Result register: one cycle from in_valid to out_valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      c_q         <= 32'h0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        c_q <= c_s;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign c         = c_q;

endmodule

module single_sum_v #(
  parameter int WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH-1:0][31:0] vector_a,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            sum
`ifdef SINGLE_SUM_NAN_FLAG_EN
  ,
  output logic                   nan_inf
`endif
);

  localparam int IDX_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0][31:0] vec_q, vec_d;
  logic [31:0]            acc_q, acc_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [31:0]            sum_q, sum_d;
  logic [31:0]            add_b_s, add_c_s;
  logic                   add_in_valid_s, add_out_valid_s;

`ifdef SINGLE_SUM_NAN_FLAG_EN
  logic nan_inf_q, nan_inf_d, any_nonfinite_s;

  // True for infinities and NaNs (all-ones exponent).
  function automatic logic is_nonfinite(input logic [31:0] x);
    return (x[30:23] == 8'hFF);
  endfunction

  // Scan the incoming vector for any non-finite element.
  always_comb begin
    any_nonfinite_s = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (is_nonfinite(vector_a[i])) begin
        any_nonfinite_s = 1'b1;
      end else begin
        any_nonfinite_s = any_nonfinite_s;
      end
    end
  end
`endif

  // Select the captured element addressed by idx as the adder's b operand.
  always_comb begin
    add_b_s = 32'h0;
    for (int i = 0; i < WIDTH; i++) begin
      if (idx_q == IDX_W'(i)) begin
        add_b_s = vec_q[i];
      end else begin
        add_b_s = add_b_s;
      end
    end
  end

  single_add_1clk u_add (
    .clk       (clk),
    .rstn      (!rst),
    .in_valid  (add_in_valid_s),
    .a         (acc_q),
    .b         (add_b_s),
    .out_valid (add_out_valid_s),
    .c         (add_c_s)
  );

  // Next-state and datapath control: capture, issue one add, wait for it.
  always_comb begin
    state_d        = state_q;
    vec_d          = vec_q;
    acc_d          = acc_q;
    idx_d          = idx_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    sum_d          = sum_q;
    add_in_valid_s = 1'b0;
`ifdef SINGLE_SUM_NAN_FLAG_EN
    nan_inf_d      = nan_inf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          vec_d = vector_a;
          acc_d = vector_a[0];
          idx_d = IDX_W'(1);
`ifdef SINGLE_SUM_NAN_FLAG_EN
          nan_inf_d = any_nonfinite_s;
`endif
          if (WIDTH == 1) begin
            // Nothing to add: the lone element is the result.
            sum_d   = vector_a[0];
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            busy_d  = 1'b1;
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        add_in_valid_s = 1'b1;
        state_d        = ST_WAIT;
      end
      ST_WAIT: begin
        if (add_out_valid_s) begin
          acc_d = add_c_s;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(WIDTH - 1)) begin
            sum_d   = add_c_s;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; rst aborts any request in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      vec_q     <= '0;
      acc_q     <= 32'h0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sum_q     <= 32'h0;
`ifdef SINGLE_SUM_NAN_FLAG_EN
      nan_inf_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sum_q     <= sum_d;
`ifdef SINGLE_SUM_NAN_FLAG_EN
      nan_inf_q <= nan_inf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
`ifdef SINGLE_SUM_NAN_FLAG_EN
  assign nan_inf = nan_inf_q;
`endif

endmodule

// File: tb/tb_single_sum_v.sv
// Directed bench for single_sum_v: a WIDTH=4 and a WIDTH=1 instance.
module tb_single_sum_v;

  logic            clk = 1'b0;
  logic            rst4, rst1, start4, start1;
  logic [3:0][31:0] va4;
  logic [0:0][31:0] va1;
  logic            busy4, done4, busy1, done1;
  logic [31:0]     sum4, sum1;
`ifdef SINGLE_SUM_NAN_FLAG_EN
  logic            nan4, nan1;
`endif
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  single_sum_v #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst4), .start(start4), .vector_a(va4),
    .busy(busy4), .done(done4), .sum(sum4)
`ifdef SINGLE_SUM_NAN_FLAG_EN
    , .nan_inf(nan4)
`endif
  );

  single_sum_v #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1), .vector_a(va1),
    .busy(busy1), .done(done1), .sum(sum1)
`ifdef SINGLE_SUM_NAN_FLAG_EN
    , .nan_inf(nan1)
`endif
  );

  // Present a vector with start for one cycle; returns 1 ns into cycle 1.
  task automatic accept4(input logic [31:0] v0, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [31:0] v3);
    @(negedge clk);
    va4[0] = v0; va4[1] = v1; va4[2] = v2; va4[3] = v3;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
  endtask

  task automatic test_reset;
    rst4 = 1'b1; rst1 = 1'b1; start4 = 1'b0; start1 = 1'b0;
    va4 = '0; va1 = '0;
    repeat (2) @(negedge clk);
    total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL reset_busy4 got %b want 0", busy4); end
    total++; if (done4 !== 1'b0) begin bad++; $display("FAIL reset_done4 got %b want 0", done4); end
    total++; if (sum4 !== 32'h0) begin bad++; $display("FAIL reset_sum4 got %h want 00000000", sum4); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy1 got %b want 0", busy1); end
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL reset_done1 got %b want 0", done1); end
    total++; if (sum1 !== 32'h0) begin bad++; $display("FAIL reset_sum1 got %h want 00000000", sum1); end
`ifdef SINGLE_SUM_NAN_FLAG_EN
    total++; if (nan4 !== 1'b0) begin bad++; $display("FAIL reset_nan4 got %b want 0", nan4); end
`endif
    rst4 = 1'b0; rst1 = 1'b0;
  endtask

  // 1 + 2 + 3 + 4 = 10.0, done exactly in cycle 7, busy in cycles 1..6.
  task automatic test_sum4;
    accept4(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      total++; if (done4 !== 1'(c == 7)) begin bad++; $display("FAIL sum4_done cycle %0d got %b want %b", c, done4, (c == 7)); end
      total++; if (busy4 !== 1'(c >= 1 && c <= 6)) begin bad++; $display("FAIL sum4_busy cycle %0d got %b want %b", c, busy4, (c <= 6)); end
      if (c >= 7) begin
        total++; if (sum4 !== 32'h4120_0000) begin bad++; $display("FAIL sum4_sum cycle %0d got %h want 41200000", c, sum4); end
      end
    end
  endtask

  // Cancellation and small addend: 1 - 1 + 2 + 0.5 = 2.5.
  task automatic test_mixed_signs;
    accept4(32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 32'h3F00_0000);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      total++; if (done4 !== 1'(c == 7)) begin bad++; $display("FAIL mixed_done cycle %0d got %b want %b", c, done4, (c == 7)); end
    end
    total++; if (sum4 !== 32'h4020_0000) begin bad++; $display("FAIL mixed_sum got %h want 40200000", sum4); end
  endtask

  // WIDTH=1: done in cycle 1, busy never; held start gives a done every cycle.
  task automatic test_width1;
    @(negedge clk);
    va1[0] = 32'hC049_0FDB; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      total++; if (done1 !== 1'(c == 1)) begin bad++; $display("FAIL w1_done cycle %0d got %b want %b", c, done1, (c == 1)); end
      total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL w1_busy cycle %0d got %b want 0", c, busy1); end
      total++; if (sum1 !== 32'hC049_0FDB) begin bad++; $display("FAIL w1_sum cycle %0d got %h want c0490fdb", c, sum1); end
    end
    va1[0] = 32'h3F80_0000; start1 = 1'b1;
    @(negedge clk);
    total++; if (done1 !== 1'b1 || sum1 !== 32'h3F80_0000) begin bad++; $display("FAIL w1_held_a got %b/%h want 1/3f800000", done1, sum1); end
    va1[0] = 32'h4000_0000;
    @(negedge clk);
    total++; if (done1 !== 1'b1 || sum1 !== 32'h4000_0000) begin bad++; $display("FAIL w1_held_b got %b/%h want 1/40000000", done1, sum1); end
    va1[0] = 32'h4040_0000;
    @(negedge clk);
    total++; if (done1 !== 1'b1 || sum1 !== 32'h4040_0000) begin bad++; $display("FAIL w1_held_c got %b/%h want 1/40400000", done1, sum1); end
    start1 = 1'b0;
    @(negedge clk);
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL w1_held_end got %b want 0", done1); end
  endtask

  // start held high: results in cycles 7, 14, 21; busy-time starts ignored.
  task automatic test_back_to_back;
    @(negedge clk);
    for (int i = 0; i < 4; i++) va4[i] = 32'h3F80_0000;
    start4 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      total++; if (done4 !== 1'(c % 7 == 0)) begin bad++; $display("FAIL b2b_done cycle %0d got %b want %b", c, done4, (c % 7 == 0)); end
      if (c % 7 == 0) begin
        total++; if (sum4 !== 32'h4080_0000) begin bad++; $display("FAIL b2b_sum cycle %0d got %h want 40800000", c, sum4); end
      end
    end
    start4 = 1'b0;
    for (int c = 22; c <= 24; c++) begin
      @(negedge clk);
      total++; if (done4 !== 1'b0 || busy4 !== 1'b0) begin bad++; $display("FAIL b2b_idle cycle %0d got %b/%b want 0/0", c, done4, busy4); end
    end
  endtask

  // Reset in cycle 3 aborts the request; the next one completes normally.
  task automatic test_reset_abort;
    accept4(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
    repeat (3) @(negedge clk);
    rst4 = 1'b1;
    #1;
    total++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin bad++; $display("FAIL abort_ctrl got %b/%b want 0/0", busy4, done4); end
    total++; if (sum4 !== 32'h0) begin bad++; $display("FAIL abort_sum got %h want 00000000", sum4); end
    @(negedge clk);
    rst4 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++; if (done4 !== 1'b0 || busy4 !== 1'b0) begin bad++; $display("FAIL abort_quiet step %0d got %b/%b want 0/0", c, done4, busy4); end
    end
    accept4(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      total++; if (done4 !== 1'(c == 7)) begin bad++; $display("FAIL abort_restart_done cycle %0d got %b want %b", c, done4, (c == 7)); end
    end
    total++; if (sum4 !== 32'h4100_0000) begin bad++; $display("FAIL abort_restart_sum got %h want 41000000", sum4); end
  endtask

  // Operand changes after the accept cycle must not reach the result.
  task automatic test_vector_change;
    accept4(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
    for (int i = 0; i < 4; i++) va4[i] = 32'h7F80_0000;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      total++; if (done4 !== 1'(c == 7)) begin bad++; $display("FAIL vchg_done cycle %0d got %b want %b", c, done4, (c == 7)); end
    end
    total++; if (sum4 !== 32'h4080_0000) begin bad++; $display("FAIL vchg_sum got %h want 40800000", sum4); end
  endtask

`ifdef SINGLE_SUM_NAN_FLAG_EN
  // nan_inf follows the most recent accepted vector.
  task automatic test_nan_flag;
    accept4(32'h3F80_0000, 32'h7FC0_0000, 32'h3F80_0000, 32'h3F80_0000);
    repeat (7) @(negedge clk);
    total++; if (done4 !== 1'b1) begin bad++; $display("FAIL nan_done got %b want 1", done4); end
    total++; if (nan4 !== 1'b1) begin bad++; $display("FAIL nan_set got %b want 1", nan4); end
    accept4(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
    repeat (7) @(negedge clk);
    total++; if (done4 !== 1'b1) begin bad++; $display("FAIL nan_clr_done got %b want 1", done4); end
    total++; if (nan4 !== 1'b0) begin bad++; $display("FAIL nan_clr got %b want 0", nan4); end
  endtask
`endif

  initial begin
    test_reset();
    test_sum4();
    test_mixed_signs();
    test_width1();
    test_back_to_back();
    test_reset_abort();
    test_vector_change();
`ifdef SINGLE_SUM_NAN_FLAG_EN
    test_nan_flag();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/single_sum_v.md
# single_sum_v

Serial single-precision reduction: sums the WIDTH elements of a 32-bit IEEE-754 vector into one scalar. It is the vector-to-scalar counterpart of the vector-plus-scalar broadcast add, used to reduce layer outputs (dot-product partials, softmax denominators) before scalar post-processing. It time-multiplexes one `single_add_1clk` instance, trading latency for area.

## Interface
- `WIDTH`, default 10: number of vector elements; legal range 1..256.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request; sampled only when `busy`=0.
- `vector_a`  in  32 x [WIDTH]  operand vector; sampled only on the accepted `start` cycle.
- `busy`  out  1  high from the cycle after accept until the `done` cycle (exclusive).
- `done`  out  1  single-cycle pulse; `sum` valid.
- `sum`  out  32  reduction result; held until the next `done`.
- `nan_inf`  out  1  present only with `SINGLE_SUM_NAN_FLAG_EN` (see Configuration).

## Operation
- Internal: captured vector register `vec[WIDTH]`, accumulator `acc[31:0]`, index `idx` of $clog2(WIDTH+1) bits, FSM states IDLE, ISSUE, WAIT.
- One `single_add_1clk` instance: `a`=`acc`, `b`=`vec[idx]`, `in_valid` high only in ISSUE; its `rstn` driven by `!rst`. Rounding/special-value behaviour is the adder's.
- IDLE: on `start`=1, `vec`<=`vector_a`, `acc`<=`vector_a[0]`, `idx`<=1. If WIDTH=1 then `sum`<=`vector_a[0]`, `done`<=1, stay IDLE; else go ISSUE.
- ISSUE: assert adder `in_valid`; go WAIT.
- WAIT: on adder `out_valid`, `acc`<=`c`, `idx`<=`idx`+1. If `idx`=WIDTH-1 then `sum`<=`c`, `done`<=1, go IDLE; else go ISSUE.
- Summation order strictly left-to-right: ((v0+v1)+v2)+...; the bench uses the same order for its reference.
- `start` while `busy`=1 is ignored; no queueing.
- `vector_a` changes after the accept cycle do not affect the result.

## Timing
- Accept edge = cycle 0. `done` high in cycle 2*WIDTH-1 (WIDTH=1: cycle 1; WIDTH=10: cycle 19).
- `busy` high cycles 1..2*WIDTH-2; low in the `done` cycle.
- `start` high in the `done` cycle is accepted (back-to-back throughput one result per 2*WIDTH-1 cycles).
- Reset values: `busy`=0, `done`=0, `sum`=32'h0, `nan_inf`=0, FSM=IDLE, `acc`=0, `idx`=0.
- Reset asserted mid-operation: all state cleared asynchronously, no `done` produced for the aborted request; the first `start` after reset release is accepted normally.
- `done` is registered; it is never asserted in consecutive cycles unless WIDTH=1 and `start` is held high.

## Configuration
- `SINGLE_SUM_NAN_FLAG_EN` defined: `nan_inf` port exists; set on accept if any `vector_a[i]` has exponent 8'hFF, cleared on accept otherwise; valid and held from the `done` cycle until the next `done`; reset 0.
- Undefined: no `nan_inf` port, no detection logic; all other behaviour identical.

## Test plan
- WIDTH=4, `vector_a`={3F800000, 40000000, 40400000, 40800000}, one `start` -> `done` pulse exactly in cycle 7, `sum`=41200000 (10.0), `busy` high cycles 1..6.
- WIDTH=1, `vector_a[0]`=C0490FDB -> `done` in cycle 1, `sum`=C0490FDB, `busy` never high.
- WIDTH=4, `start` held high continuously with vector {3F800000 x4} -> `done` in cycles 7, 14, 21, `sum`=40800000 each; starts during `busy` have no effect.
- WIDTH=4, accept then assert `rst` in cycle 3 for one cycle -> outputs 0 immediately, no `done`; new `start` with {40000000 x4} -> `done` 7 cycles after its accept, `sum`=41000000.
- WIDTH=4, change `vector_a` to all 7F800000 in cycle 1 after accepting {3F800000 x4} -> `sum`=40800000.
- With `SINGLE_SUM_NAN_FLAG_EN`, WIDTH=4, {3F800000, 7FC00000, 3F800000, 3F800000} -> `done` cycle 7, `nan_inf`=1; next request {3F800000 x4} -> `nan_inf`=0.
